// File: rtl/ibex_pkg.sv
// Shared multiply/divide types: operator encoding and issue-side FSM states.
// No logic; no latency; no flow control.
package ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ISSUE_IDLE  = 2'd0,
    MD_ISSUE_BUSY  = 2'd1,
    MD_ISSUE_DRAIN = 2'd2,
    MD_ISSUE_RESP  = 2'd3
  } md_issue_state_e;

  function automatic logic md_op_is_div(md_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/ibex_multdiv_adder.sv
// Shared 34-bit adder and divisor zero-detect for the slow multdiv unit.
// Latency: combinational. Backpressure: none.
module ibex_multdiv_adder (
  input  logic [32:0] operand_a,
  input  logic [32:0] operand_b,
  input  logic [31:0] op_b,
  output logic [33:0] adder_ext,
  output logic [31:0] adder,
  output logic        equal_to_zero
);

  // Unsigned add; a carry out of bit 32 lands in bit 33.
  assign adder_ext     = {1'b0, operand_a} + {1'b0, operand_b};
  assign adder         = adder_ext[32:1];
  assign equal_to_zero = (op_b == 32'd0);

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Requester for the slow mul/div unit; optional one-entry result cache under MULTDIV_RESULT_CACHE_EN.
// Latency: MUL T+34, DIV/REM T+38, divide-by-zero T+3, cache hit T+1.
// Backpressure: one op in flight; response held until resp_ready_i, no accept while busy.
module ibex_multdiv_issue
  import ibex_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             CK,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_operator_i,
  input  logic [1:0]       req_signed_mode_i,
  input  logic [31:0]      req_a_i,
  input  logic [31:0]      req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             kill_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_result_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  input  logic [32:0]      md_alu_operand_a_i,
  input  logic [32:0]      md_alu_operand_b_i,
  output logic [33:0]      md_alu_adder_ext_o,
  output logic [31:0]      md_alu_adder_o,
  output logic             md_equal_to_zero_o,
  input  logic [31:0]      md_result_i,
  input  logic             md_valid_i
);

  md_issue_state_e  state_q, state_d;
  md_op_e           op_q, op_d;
  logic [1:0]       sm_q;
  logic [31:0]      a_q, b_q, result_q;
  logic [TAG_W-1:0] tag_q;
  logic             mult_en_q, div_en_q, mult_en_d, div_en_d, unit_active_d;
  logic             accept, capture, cache_hit;
  logic [31:0]      cache_res;

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    accept      = 1'b0;
    capture     = 1'b0;
    unique case (state_q)
      MD_ISSUE_IDLE: begin
        req_ready_o = ~kill_i & ~rst_i;
        if (req_valid_i && req_ready_o) begin
          accept  = 1'b1;
          state_d = cache_hit ? MD_ISSUE_RESP : MD_ISSUE_BUSY;
        end
      end
      MD_ISSUE_BUSY: begin
        if (md_valid_i) begin
          capture = ~kill_i;
          state_d = kill_i ? MD_ISSUE_IDLE : MD_ISSUE_RESP;
        end else if (kill_i) begin
          state_d = MD_ISSUE_DRAIN;
        end
      end
      // The unit cannot abort, so keep it enabled until it finishes and drop the result.
      MD_ISSUE_DRAIN: begin
        if (md_valid_i) state_d = MD_ISSUE_IDLE;
      end
      MD_ISSUE_RESP: begin
        if (resp_ready_i || kill_i) state_d = MD_ISSUE_IDLE;
      end
    endcase
  end

  assign op_d          = accept ? md_op_e'(req_operator_i) : op_q;
  assign unit_active_d = (state_d == MD_ISSUE_BUSY) || (state_d == MD_ISSUE_DRAIN);
  assign mult_en_d     = unit_active_d & ~md_op_is_div(op_d);
  assign div_en_d      = unit_active_d &  md_op_is_div(op_d);

  always_ff @(posedge CK) begin
    if (rst_i) begin
      state_q   <= MD_ISSUE_IDLE;
      op_q      <= MD_OP_MULL;
      sm_q      <= 2'b00;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      tag_q     <= '0;
      result_q  <= 32'd0;
      mult_en_q <= 1'b0;
      div_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mult_en_q <= mult_en_d;
      div_en_q  <= div_en_d;
      if (accept) begin
        op_q  <= op_d;
        sm_q  <= req_signed_mode_i;
        a_q   <= req_a_i;
        b_q   <= req_b_i;
        tag_q <= req_tag_i;
      end
      if (capture) begin
        result_q <= md_result_i;
      end else if (accept && cache_hit) begin
        result_q <= cache_res;
      end
    end
  end

`ifdef MULTDIV_RESULT_CACHE_EN
  logic        cache_vld_q;
  md_op_e      cache_op_q;
  logic [1:0]  cache_sm_q;
  logic [31:0] cache_a_q, cache_b_q, cache_res_q;

  assign cache_hit = cache_vld_q && (cache_op_q == md_op_e'(req_operator_i)) &&
                     (cache_sm_q == req_signed_mode_i) &&
                     (cache_a_q == req_a_i) && (cache_b_q == req_b_i);
  assign cache_res = cache_res_q;

  // Operands are already held in op_q/sm_q/a_q/b_q when the unit result arrives.
  always_ff @(posedge CK) begin
    if (rst_i) begin
      cache_vld_q <= 1'b0;
      cache_op_q  <= MD_OP_MULL;
      cache_sm_q  <= 2'b00;
      cache_a_q   <= 32'd0;
      cache_b_q   <= 32'd0;
      cache_res_q <= 32'd0;
    end else if (capture) begin
      cache_vld_q <= 1'b1;
      cache_op_q  <= op_q;
      cache_sm_q  <= sm_q;
      cache_a_q   <= a_q;
      cache_b_q   <= b_q;
      cache_res_q <= md_result_i;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = 32'd0;
`endif

  assign resp_valid_o     = (state_q == MD_ISSUE_RESP);
  assign resp_result_o    = result_q;
  assign resp_tag_o       = tag_q;
  assign busy_o           = (state_q != MD_ISSUE_IDLE);
  assign md_mult_en_o     = mult_en_q;
  assign md_div_en_o      = div_en_q;
  assign md_operator_o    = op_q;
  assign md_signed_mode_o = sm_q;
  assign md_op_a_o        = a_q;
  assign md_op_b_o        = b_q;

  ibex_multdiv_adder u_adder (
    .operand_a     (md_alu_operand_a_i),
    .operand_b     (md_alu_operand_b_i),
    .op_b          (b_q),
    .adder_ext     (md_alu_adder_ext_o),
    .adder         (md_alu_adder_o),
    .equal_to_zero (md_equal_to_zero_o)
  );

endmodule
